mannix_job_dispatch: RTL and testbench

- Parametrised job dispatcher between the software register interface and NUM_ACC accelerator channels (fcc/pool/cnn class units).
- Replaces direct per-accelerator go/done wiring with per-channel descriptor queues, automatic go issue and a tagged completion stream.
- Sits in the mannix top level, beside the accelerators and mannix_mem_farm.

---
 rtl/mannix_dispatch_pkg.sv | 27 ++
 rtl/mannix_job_fifo.sv | 61 ++++++
 rtl/mannix_job_dispatch.sv | 195 +++++++++++++++++++
 tb/tb_mannix_job_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mannix_dispatch_pkg.sv
// Shared types and width helpers for the mannix job dispatcher.
package mannix_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    WAIT = 2'd2,
    CMPL = 2'd3
  } ch_state_e;

  localparam int JOB_TAG_W  = 8;
  localparam int JOB_DESC_W = 64;

  typedef struct packed {
    logic [JOB_TAG_W-1:0]  tag;
    logic [JOB_DESC_W-1:0] desc;
  } job_t;

  function automatic int acc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mannix_job_fifo.sv
// Per-channel job queue: synchronous FIFO with full/empty/occupancy.
// Pushes while full and pops while empty are ignored.
module mannix_job_fifo
  import mannix_dispatch_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = job_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  item_t                    din,
  input  logic                     pop,
  output item_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LW    = lvl_w(DEPTH);

  item_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == LW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = cnt;

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      else         wr_ptr <= wr_ptr;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      else         rd_ptr <= rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mannix_job_dispatch.sv
// Job dispatcher: per-channel descriptor queues, automatic go issue and a
// round-robin tagged completion stream. Optional watchdog: MANNIX_DISPATCH_TIMEOUT_EN.
module mannix_job_dispatch
  import mannix_dispatch_pkg::*;
#(
  parameter int NUM_ACC     = 3,
  parameter int Q_DEPTH     = 4,
  parameter int DESC_W      = JOB_DESC_W,
  parameter int TAG_W       = JOB_TAG_W,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sw_job_valid,
  output logic                                 sw_job_ready,
  input  logic [acc_id_w(NUM_ACC)-1:0]         sw_job_acc,
  input  logic [TAG_W-1:0]                     sw_job_tag,
  input  logic [DESC_W-1:0]                    sw_job_desc,
  output logic                                 sw_err,
  input  logic                                 sw_err_clr,
  output logic [NUM_ACC-1:0]                   acc_go,
  output logic [NUM_ACC*DESC_W-1:0]            acc_desc,
  input  logic [NUM_ACC-1:0]                   acc_busy,
  input  logic [NUM_ACC-1:0]                   acc_done,
  output logic                                 cmp_valid,
  input  logic                                 cmp_ready,
  output logic [acc_id_w(NUM_ACC)-1:0]         cmp_acc,
  output logic [TAG_W-1:0]                     cmp_tag,
  output logic                                 cmp_timeout,
  output logic [NUM_ACC*lvl_w(Q_DEPTH)-1:0]    q_level
);

  localparam int ACC_ID_W = acc_id_w(NUM_ACC);
  localparam int LVL_W    = lvl_w(Q_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DESC_W-1:0] desc;
  } ch_job_t;

  ch_job_t                         push_job;
  logic [NUM_ACC-1:0]              full;
  logic [NUM_ACC-1:0]              empty;
  logic [NUM_ACC-1:0]              push;
  logic [NUM_ACC-1:0]              pop;
  logic [NUM_ACC-1:0]              in_cmpl;
  logic [NUM_ACC-1:0]              tmo_flag;
  logic [NUM_ACC-1:0]              gnt_hs;
  logic [NUM_ACC-1:0][TAG_W-1:0]   tag_all;
  logic                            id_bad;
  logic                            sel_full;
  logic                            found;
  logic                            hs;
  logic [ACC_ID_W-1:0]             rr_ptr;
  logic [ACC_ID_W-1:0]             grant;
  int                              idx;

  assign push_job = '{tag: sw_job_tag, desc: sw_job_desc};

  // push acceptance; a full queue blocks even if it pops this cycle
  always_comb begin
    id_bad   = {1'b0, sw_job_acc} >= (ACC_ID_W + 1)'(NUM_ACC);
    sel_full = 1'b0;
    push     = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      sel_full = sel_full | (full[i] & (sw_job_acc == ACC_ID_W'(i)));
    end
    sw_job_ready = !rst && (id_bad || !sel_full);
    for (int i = 0; i < NUM_ACC; i++) begin
      push[i] = sw_job_valid && sw_job_ready && !id_bad && (sw_job_acc == ACC_ID_W'(i));
    end
  end

  // sticky invalid-channel flag; clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst)                                         sw_err <= 1'b0;
    else if (sw_err_clr)                             sw_err <= 1'b0;
    else if (sw_job_valid && sw_job_ready && id_bad) sw_err <= 1'b1;
    else                                             sw_err <= sw_err;
  end

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_ch
    ch_job_t          head;
    ch_job_t          cur;
    ch_state_e        state;
    ch_state_e        nxt;
    logic             tmo_hit;
    logic [LVL_W-1:0] lvl;

    mannix_job_fifo #(
      .DEPTH  (Q_DEPTH),
      .item_t (ch_job_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (push_job),
      .pop   (pop[g]),
      .dout  (head),
      .full  (full[g]),
      .empty (empty[g]),
      .level (lvl)
    );

    assign pop[g]     = (state == IDLE) && !empty[g] && !acc_busy[g];
    assign in_cmpl[g] = (state == CMPL);
    assign acc_go[g]  = (state == GO) && !rst;
    assign tag_all[g] = cur.tag;
    assign acc_desc[g*DESC_W +: DESC_W] = cur.desc;
    assign q_level[g*LVL_W +: LVL_W]    = lvl;

    // channel next state; done outside WAIT is ignored
    always_comb begin
      nxt = state;
      case (state)
        IDLE:    nxt = pop[g] ? GO : IDLE;
        GO:      nxt = WAIT;
        WAIT:    nxt = (acc_done[g] || tmo_hit) ? CMPL : WAIT;
        CMPL:    nxt = gnt_hs[g] ? IDLE : CMPL;
        default: nxt = IDLE;
      endcase
    end

    // channel state and in-flight job; cur keeps its value until the next pop
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cur   <= '0;
      end else begin
        state <= nxt;
        if (pop[g]) cur <= head;
        else        cur <= cur;
      end
    end

`ifdef MANNIX_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] wd_cnt;
    logic             tmo_q;

    assign tmo_hit     = (state == WAIT) && !acc_done[g] && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign tmo_flag[g] = tmo_q;

    // watchdog counter cleared on the pop that enters GO
    always_ff @(posedge clk) begin
      if (rst) begin
        wd_cnt <= '0;
        tmo_q  <= 1'b0;
      end else begin
        if (pop[g])              wd_cnt <= '0;
        else if (state == WAIT)  wd_cnt <= wd_cnt + CNT_W'(1);
        else                     wd_cnt <= wd_cnt;
        if ((state == WAIT) && (nxt == CMPL)) tmo_q <= tmo_hit;
        else                                  tmo_q <= tmo_q;
      end
    end
`else
    assign tmo_hit     = 1'b0;
    assign tmo_flag[g] = 1'b0;
`endif
  end

  // round-robin grant starting at rr_ptr over channels in CMPL
  always_comb begin
    found  = 1'b0;
    grant  = '0;
    idx    = 0;
    gnt_hs = '0;
    for (int off = 0; off < NUM_ACC; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_ACC;
      if (!found && in_cmpl[idx]) begin
        found = 1'b1;
        grant = ACC_ID_W'(idx);
      end else begin
        found = found;
      end
    end
    cmp_valid   = found && !rst;
    hs          = cmp_valid && cmp_ready;
    cmp_acc     = grant;
    cmp_tag     = tag_all[grant];
    cmp_timeout = cmp_valid && tmo_flag[grant];
    for (int i = 0; i < NUM_ACC; i++) begin
      gnt_hs[i] = hs && (grant == ACC_ID_W'(i));
    end
  end

  // pointer moves past the winner only on handshake
  always_ff @(posedge clk) begin
    if (rst)     rr_ptr <= '0;
    else if (hs) rr_ptr <= (grant == ACC_ID_W'(NUM_ACC - 1)) ? '0 : grant + ACC_ID_W'(1);
    else         rr_ptr <= rr_ptr;
  end

endmodule

// File: tb/tb_mannix_job_dispatch.sv
// Scoreboard bench for mannix_job_dispatch: directed jobs push expected
// go/completion records; negedge monitors pop and compare.
module tb_mannix_job_dispatch;

  localparam int NUM_ACC = 3;
  localparam int DESC_W  = 64;
  localparam int TAG_W   = 8;
`ifdef MANNIX_DISPATCH_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65536;
`endif

  logic                        clk;
  logic                        rst;
  logic                        sw_job_valid;
  logic                        sw_job_ready;
  logic [1:0]                  sw_job_acc;
  logic [TAG_W-1:0]            sw_job_tag;
  logic [DESC_W-1:0]           sw_job_desc;
  logic                        sw_err;
  logic                        sw_err_clr;
  logic [NUM_ACC-1:0]          acc_go;
  logic [NUM_ACC*DESC_W-1:0]   acc_desc;
  logic [NUM_ACC-1:0]          acc_busy;
  logic [NUM_ACC-1:0]          acc_done;
  logic                        cmp_valid;
  logic                        cmp_ready;
  logic [1:0]                  cmp_acc;
  logic [TAG_W-1:0]            cmp_tag;
  logic                        cmp_timeout;
  logic [8:0]                  q_level;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] desc;
  } go_t;

  typedef struct packed {
    logic [1:0] acc;
    logic [7:0] tag;
    logic       tmo;
  } cmp_t;

  go_t  exp_go[$];
  cmp_t exp_cmp[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rdy;

  mannix_job_dispatch #(
    .NUM_ACC     (NUM_ACC),
    .Q_DEPTH     (4),
    .DESC_W      (DESC_W),
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_job_valid (sw_job_valid),
    .sw_job_ready (sw_job_ready),
    .sw_job_acc   (sw_job_acc),
    .sw_job_tag   (sw_job_tag),
    .sw_job_desc  (sw_job_desc),
    .sw_err       (sw_err),
    .sw_err_clr   (sw_err_clr),
    .acc_go       (acc_go),
    .acc_desc     (acc_desc),
    .acc_busy     (acc_busy),
    .acc_done     (acc_done),
    .cmp_valid    (cmp_valid),
    .cmp_ready    (cmp_ready),
    .cmp_acc      (cmp_acc),
    .cmp_tag      (cmp_tag),
    .cmp_timeout  (cmp_timeout),
    .q_level      (q_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // go monitor: every go pulse must match an outstanding expected job
  always @(negedge clk) begin
    for (int c = 0; c < NUM_ACC; c++) begin
      if (acc_go[c] === 1'b1) begin
        int k;
        k = -1;
        for (int j = 0; j < exp_go.size(); j++) begin
          if (k < 0 && int'(exp_go[j].ch) == c) k = j;
        end
        if (k < 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_go: actual go on ch %0d required none", c);
        end else begin
          check("go_desc", acc_desc[c*DESC_W +: DESC_W], exp_go[k].desc);
          exp_go.delete(k);
        end
      end
    end
  end

  // completion monitor: pops in order on each handshake
  always @(negedge clk) begin
    if (cmp_valid === 1'b1 && cmp_ready === 1'b1) begin
      cmp_t e;
      if (exp_cmp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cmp: actual acc=%0d tag=%0h required none", cmp_acc, cmp_tag);
      end else begin
        e = exp_cmp.pop_front();
        check("cmp_acc", 64'(cmp_acc), 64'(e.acc));
        check("cmp_tag", 64'(cmp_tag), 64'(e.tag));
        check("cmp_timeout", 64'(cmp_timeout), 64'(e.tmo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] acc, input logic [7:0] tag, input logic [63:0] desc,
                      input logic issue, output logic ok);
    sw_job_valid = 1'b1;
    sw_job_acc   = acc;
    sw_job_tag   = tag;
    sw_job_desc  = desc;
    #1;
    ok = sw_job_ready;
    if (ok && issue) exp_go.push_back('{ch: acc, desc: desc});
    @(posedge clk);
    #1;
    sw_job_valid = 1'b0;
  endtask

  task automatic wait_go(input int ch);
    int t;
    t = 0;
    while (acc_go[ch] !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("go_within_budget", 64'(t < 20), 64'd1);
  endtask

  // called while the channel shows go; pulses done in the WAIT cycle
  task automatic finish_job(input logic [1:0] ch, input logic [7:0] tag);
    tick();
    acc_done[ch] = 1'b1;
    exp_cmp.push_back('{acc: ch, tag: tag, tmo: 1'b0});
    tick();
    acc_done[ch] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_job_valid = 1'b0; sw_job_acc = 2'd0; sw_job_tag = 8'd0;
    sw_job_desc = 64'd0; sw_err_clr = 1'b0; acc_busy = 3'b000; acc_done = 3'b000;
    cmp_ready = 1'b0;
    repeat (3) tick();
    check("rst_go", 64'(acc_go), 64'd0);
    check("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    check("rst_q_level", 64'(q_level), 64'd0);
    check("rst_sw_err", 64'(sw_err), 64'd0);
    check("rst_desc", 64'(acc_desc[63:0]), 64'd0);
    sw_job_valid = 1'b1;
    #1;
    check("rst_ready", 64'(sw_job_ready), 64'd0);
    sw_job_valid = 1'b0;
    rst = 1'b0;
    tick();

    // single job on ch1, go two edges after acceptance
    cmp_ready = 1'b1;
    push(2'd1, 8'h11, 64'hA5, 1'b1, rdy);
    check("t1_ready", 64'(rdy), 64'd1);
    tick();
    check("t1_go", 64'(acc_go), 64'b010);
    check("t1_desc", acc_desc[127:64], 64'hA5);
    tick();
    check("t1_go_once", 64'(acc_go), 64'd0);
    acc_done[1] = 1'b1;
    exp_cmp.push_back('{acc: 2'd1, tag: 8'h11, tmo: 1'b0});
    tick();
    acc_done[1] = 1'b0;
    check("t1_cmp_valid", 64'(cmp_valid), 64'd1);
    tick();
    check("t1_desc_held", acc_desc[127:64], 64'hA5);

    // fill ch0 while busy, fifth push blocked
    acc_busy[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(2'd0, 8'h20 + 8'(i), 64'h100 + 64'(i), 1'b1, rdy);
      check("t2_ready", 64'(rdy), 64'(i < 4));
    end
    check("t2_level_full", 64'(q_level[2:0]), 64'd4);
    check("t2_no_go", 64'(acc_go), 64'd0);
    acc_busy[0] = 1'b0;
    tick();
    check("t2_level_pop", 64'(q_level[2:0]), 64'd3);
    check("t2_go", 64'(acc_go[0]), 64'd1);
    for (int j = 0; j < 4; j++) begin
      wait_go(0);
      finish_job(2'd0, 8'h20 + 8'(j));
    end
    repeat (3) tick();

    // invalid channel id
    push(2'd3, 8'h33, 64'hDEAD, 1'b0, rdy);
    check("t3_ready", 64'(rdy), 64'd1);
    check("t3_sw_err", 64'(sw_err), 64'd1);
    check("t3_level", 64'(q_level), 64'd0);
    tick();
    sw_err_clr = 1'b1;
    tick();
    sw_err_clr = 1'b0;
    check("t3_err_clr", 64'(sw_err), 64'd0);
    sw_err_clr = 1'b1;
    push(2'd3, 8'h34, 64'hBEEF, 1'b0, rdy);
    sw_err_clr = 1'b0;
    check("t3_clr_priority", 64'(sw_err), 64'd0);

    // reset while ch2 is in WAIT with two jobs queued
    push(2'd2, 8'h50, 64'h500, 1'b1, rdy);
    tick();
    tick();
    push(2'd2, 8'h51, 64'h501, 1'b0, rdy);
    push(2'd2, 8'h52, 64'h502, 1'b0, rdy);
    check("t5_level", 64'(q_level[8:6]), 64'd2);
    rst = 1'b1;
    tick();
    check("t5_rst_level", 64'(q_level), 64'd0);
    check("t5_rst_ready", 64'(sw_job_ready), 64'd0);
    rst = 1'b0;
    tick();
    acc_done[2] = 1'b1;
    tick();
    acc_done[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_cmp", 64'(cmp_valid), 64'd0);
      check("t5_no_go", 64'(acc_go), 64'd0);
      tick();
    end

    // three simultaneous completions, held then drained in order
    cmp_ready = 1'b0;
    push(2'd0, 8'h40, 64'h400, 1'b1, rdy);
    push(2'd1, 8'h41, 64'h401, 1'b1, rdy);
    push(2'd2, 8'h42, 64'h402, 1'b1, rdy);
    repeat (4) tick();
    check("t4_waiting", 64'(cmp_valid), 64'd0);
    acc_done = 3'b111;
    tick();
    acc_done = 3'b000;
    exp_cmp.push_back('{acc: 2'd0, tag: 8'h40, tmo: 1'b0});
    exp_cmp.push_back('{acc: 2'd1, tag: 8'h41, tmo: 1'b0});
    exp_cmp.push_back('{acc: 2'd2, tag: 8'h42, tmo: 1'b0});
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", 64'(cmp_valid), 64'd1);
      check("t4_hold_acc", 64'(cmp_acc), 64'd0);
      check("t4_hold_tag", 64'(cmp_tag), 64'h40);
      tick();
    end
    cmp_ready = 1'b1;
    repeat (4) tick();
    check("t4_drained", 64'(cmp_valid), 64'd0);

`ifdef MANNIX_DISPATCH_TIMEOUT_EN
    // watchdog fires 16 cycles after entering WAIT
    push(2'd1, 8'h66, 64'h600, 1'b1, rdy);
    tick();
    check("t6_go", 64'(acc_go[1]), 64'd1);
    tick();
    repeat (15) tick();
    check("t6_not_yet", 64'(cmp_valid), 64'd0);
    exp_cmp.push_back('{acc: 2'd1, tag: 8'h66, tmo: 1'b1});
    tick();
    check("t6_tmo_valid", 64'(cmp_valid), 64'd1);
    check("t6_tmo_flag", 64'(cmp_timeout), 64'd1);
    tick();
    // done on the terminal count wins over the watchdog
    push(2'd1, 8'h67, 64'h601, 1'b1, rdy);
    tick();
    tick();
    repeat (15) tick();
    acc_done[1] = 1'b1;
    exp_cmp.push_back('{acc: 2'd1, tag: 8'h67, tmo: 1'b0});
    tick();
    acc_done[1] = 1'b0;
    check("t6_done_valid", 64'(cmp_valid), 64'd1);
    check("t6_done_wins", 64'(cmp_timeout), 64'd0);
    tick();
`endif

    repeat (10) tick();
    check("go_queue_empty", 64'(exp_go.size()), 64'd0);
    check("cmp_queue_empty", 64'(exp_cmp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
